// File: rtl/fifo_buffer.sv
// Single-clock FIFO leaf: register-array storage, registered read port, full/empty flags.
// Define FIFO_BUFFER_CHECK_EN to report dropped writes and ignored reads in simulation.
module fifo_buffer #(
  parameter int DATA_WIDTH        = 32,
  parameter int BUFFER_ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  wren_i,
  input  logic                  rden_i,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  empty_o,
  output logic                  full_o
);

  localparam int AW    = BUFFER_ADDR_WIDTH;
  localparam int DEPTH = 1 << AW;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]         wptr;
  logic [AW-1:0]         rptr;
  logic [AW:0]           count;
  logic [AW:0]           count_nxt;
  logic                  wr_ok;
  logic                  rd_ok;

  // A read on a full FIFO frees a slot on the same edge, so the write may land.
  assign wr_ok = wren_i && (!full_o || rden_i);
  assign rd_ok = rden_i && !empty_o;

  assign empty_o = (count == '0);
  assign full_o  = (count == FULL_CNT);

  always_comb begin
    count_nxt = count;
    unique case ({wr_ok, rd_ok})
      2'b10:   count_nxt = count + (AW+1)'(1);
      2'b01:   count_nxt = count - (AW+1)'(1);
      default: count_nxt = count;
    endcase
  end

  // Storage has no reset; stale contents are unreachable once pointers clear.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wptr] <= data_i;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      count <= count_nxt;
      if (wr_ok) begin
        wptr <= wptr + AW'(1);
      end
      if (rd_ok) begin
        rptr <= rptr + AW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      data_o <= '0;
    end else if (rd_ok) begin
      data_o <= mem[rptr];
    end
  end

`ifdef FIFO_BUFFER_CHECK_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      if (wren_i && full_o && !rden_i) begin
        $display("%0t fifo_buffer error: write dropped while full", $time);
      end
      if (rden_i && empty_o) begin
        $display("%0t fifo_buffer error: read ignored while empty", $time);
      end
    end
  end
`else
`endif

endmodule

// File: tb/tb_fifo_buffer.sv
// Self-checking bench for fifo_buffer (36-bit words, 32 entries).
// Expected read data comes from a scoreboard queue filled as writes are driven.
module tb_fifo_buffer;

  localparam int DW    = 36;
  localparam int AW    = 5;
  localparam int DEPTH = 1 << AW;

  logic          clk;
  logic          reset;
  logic [DW-1:0] data_i;
  logic          wren_i;
  logic          rden_i;
  logic [DW-1:0] data_o;
  logic          empty_o;
  logic          full_o;

  logic [DW-1:0] sb[$];
  logic [DW-1:0] exp_data;
  int            n_checks;
  int            n_fail;

  fifo_buffer #(
    .DATA_WIDTH(DW),
    .BUFFER_ADDR_WIDTH(AW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .data_i(data_i),
    .wren_i(wren_i),
    .rden_i(rden_i),
    .data_o(data_o),
    .empty_o(empty_o),
    .full_o(full_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rnd();
    return DW'({$urandom(), $urandom()});
  endfunction

  // Drive one cycle and advance the scoreboard with the expected acceptance.
  task automatic step(input logic w, input logic r, input logic [DW-1:0] d);
    bit rd_ok;
    bit wr_ok;
    rd_ok = r && (sb.size() > 0);
    wr_ok = w && ((sb.size() < DEPTH) || r);
    if (rd_ok) exp_data = sb.pop_front();
    if (wr_ok) sb.push_back(d);
    wren_i = w;
    rden_i = r;
    data_i = d;
    @(posedge clk);
    #1;
    wren_i = 1'b0;
    rden_i = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #12;
    reset = 1'b0;
    sb.delete();
    exp_data = '0;
    @(posedge clk);
    #1;
    n_checks++;
    if (empty_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_empty got=%b want=1", empty_o);
    end
    n_checks++;
    if (full_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_full got=%b want=0", full_o);
    end
    n_checks++;
    if (data_o !== '0) begin
      n_fail++;
      $display("FAIL reset_data got=%h want=0", data_o);
    end
  endtask

  task automatic test_single();
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b0, rnd());
      n_checks++;
      if (empty_o !== 1'b0) begin
        n_fail++;
        $display("FAIL single_nonempty[%0d] got=%b want=0", i, empty_o);
      end
      step(1'b0, 1'b1, '0);
      n_checks++;
      if (data_o !== exp_data) begin
        n_fail++;
        $display("FAIL single_data[%0d] got=%h want=%h", i, data_o, exp_data);
      end
      n_checks++;
      if (empty_o !== 1'b1) begin
        n_fail++;
        $display("FAIL single_empty[%0d] got=%b want=1", i, empty_o);
      end
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, DW'(36'hA00 + i));
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b1, '0);
      n_checks++;
      if (data_o !== exp_data) begin
        n_fail++;
        $display("FAIL b2b_data[%0d] got=%h want=%h", i, data_o, exp_data);
      end
    end
    n_checks++;
    if (empty_o !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_empty got=%b want=1", empty_o);
    end
  endtask

  task automatic test_full();
    for (int i = 0; i < DEPTH; i++) begin
      n_checks++;
      if (full_o !== 1'b0) begin
        n_fail++;
        $display("FAIL full_early[%0d] got=%b want=0", i, full_o);
      end
      step(1'b1, 1'b0, rnd());
    end
    n_checks++;
    if (full_o !== 1'b1) begin
      n_fail++;
      $display("FAIL full_set got=%b want=1", full_o);
    end
    step(1'b1, 1'b0, 36'hDEAD_BEEF_5);
    n_checks++;
    if (full_o !== 1'b1) begin
      n_fail++;
      $display("FAIL full_drop got=%b want=1", full_o);
    end
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 1'b1, '0);
      n_checks++;
      if (data_o !== exp_data) begin
        n_fail++;
        $display("FAIL full_read[%0d] got=%h want=%h", i, data_o, exp_data);
      end
    end
    n_checks++;
    if (empty_o !== 1'b1 || full_o !== 1'b0) begin
      n_fail++;
      $display("FAIL full_drain got=%b%b want=10", empty_o, full_o);
    end
  endtask

  task automatic test_empty_read();
    logic [DW-1:0] held;
    held = data_o;
    step(1'b0, 1'b1, '0);
    n_checks++;
    if (data_o !== held) begin
      n_fail++;
      $display("FAIL empty_hold got=%h want=%h", data_o, held);
    end
    n_checks++;
    if (empty_o !== 1'b1) begin
      n_fail++;
      $display("FAIL empty_flag got=%b want=1", empty_o);
    end
    step(1'b1, 1'b1, 36'h1_2345_6789);
    n_checks++;
    if (data_o !== held) begin
      n_fail++;
      $display("FAIL empty_nofall got=%h want=%h", data_o, held);
    end
    step(1'b0, 1'b1, '0);
    n_checks++;
    if (data_o !== 36'h1_2345_6789) begin
      n_fail++;
      $display("FAIL empty_rw_data got=%h want=123456789", data_o);
    end
  endtask

  task automatic test_full_rw();
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, rnd());
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b1, rnd());
      n_checks++;
      if (data_o !== exp_data || full_o !== 1'b1) begin
        n_fail++;
        $display("FAIL fullrw[%0d] got=%h/%b want=%h/1", i, data_o, full_o, exp_data);
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b0, 1'b1, '0);
      n_checks++;
      if (data_o !== exp_data) begin
        n_fail++;
        $display("FAIL fullrw_drain[%0d] got=%h want=%h", i, data_o, exp_data);
      end
    end
    n_checks++;
    if (empty_o !== 1'b1) begin
      n_fail++;
      $display("FAIL fullrw_empty got=%b want=1", empty_o);
    end
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] d;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, rnd());
    #2;
    reset = 1'b1;
    #1;
    sb.delete();
    exp_data = '0;
    n_checks++;
    if (empty_o !== 1'b1 || full_o !== 1'b0) begin
      n_fail++;
      $display("FAIL midrst_flags got=%b%b want=10", empty_o, full_o);
    end
    n_checks++;
    if (data_o !== '0) begin
      n_fail++;
      $display("FAIL midrst_data got=%h want=0", data_o);
    end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    d = rnd();
    step(1'b1, 1'b0, d);
    step(1'b0, 1'b1, '0);
    n_checks++;
    if (data_o !== d) begin
      n_fail++;
      $display("FAIL midrst_new got=%h want=%h", data_o, d);
    end
    n_checks++;
    if (empty_o !== 1'b1) begin
      n_fail++;
      $display("FAIL midrst_empty got=%b want=1", empty_o);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    wren_i   = 1'b0;
    rden_i   = 1'b0;
    data_i   = '0;
    exp_data = '0;
    #3;
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_empty_read();
    test_full_rw();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
